// File: rtl/rom_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter_if
// Bundles the two requester ports and the ROM-facing port of the
// ROM access arbiter.
//
// Signals:
//   req0/addr0    port 0 (ID lookup) request pulse and read address
//   req1/addr1    port 1 (credential lookup) request pulse and read address
//   gnt0/gnt1     one-cycle pulse: request accepted into service
//   vld0/vld1     one-cycle pulse: rd_data holds that port's result
//   rd_data       registered read result
//   busy          arbiter active or holding a pending request
//   rom_addr      registered address to the ROM
//   rom_q         ROM read data
//
// Modports:
//   slave   the arbiter itself
//   master  the environment (requesters plus ROM)
// -----------------------------------------------------------------------------
interface rom_access_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt0;
    logic          gnt1;
    logic          vld0;
    logic          vld1;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;

    modport slave (
        input  req0, addr0, req1, addr1, rom_q,
        output gnt0, gnt1, vld0, vld1, rd_data, busy, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_q,
        input  gnt0, gnt1, vld0, vld1, rd_data, busy, rom_addr
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// -----------------------------------------------------------------------------
// rom_access_arbiter
// Shares one synchronous single-port ROM between two requesters (port 0: ID
// lookup, port 1: credential lookup). Each port may hold one pending request;
// pending requests are served round-robin. The sequencer drives the ROM
// address, waits out the read latency and returns the word with a per-port
// valid pulse. If the winning address equals the address already on the ROM
// and the ROM output has settled, the wait is skipped (HIT path).
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   synchronous reset, active-high
//   bus     rom_access_arbiter_if.slave (requesters + ROM)
//
// Parameters:
//   AW        ROM address width
//   DW        ROM data width
//   READ_LAT  cycles from rom_addr change to valid rom_q (1..7)
// -----------------------------------------------------------------------------
module rom_access_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 16,
    parameter int READ_LAT = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rom_access_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    // Last WAIT cycle: rom_addr has then been stable for READ_LAT cycles.
    localparam logic [2:0] CNT_LAST = 3'(READ_LAT - 1);

    state_t        state_q,    state_d;
    logic          pend0_q,    pend0_d;
    logic          pend1_q,    pend1_d;
    logic [AW-1:0] paddr0_q,   paddr0_d;
    logic [AW-1:0] paddr1_q,   paddr1_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;
    logic          gnt0_q,     gnt0_d;
    logic          gnt1_q,     gnt1_d;
    logic          vld0_q,     vld0_d;
    logic          vld1_q,     vld1_d;
    logic          last_q,     last_d;
    logic          owner_q,    owner_d;
    logic [2:0]    cnt_q,      cnt_d;
    logic          addr_ok_q,  addr_ok_d;

    logic          grant_s;
    logic          win_port_s;
    logic [AW-1:0] win_addr_s;
    logic          hit_s;

    // Round-robin winner selection and hit detection for the IDLE state.
    always_comb begin
        win_port_s = 1'b0;
        if (pend0_q && pend1_q) begin
            win_port_s = ~last_q;
        end else if (pend1_q) begin
            win_port_s = 1'b1;
        end else begin
            win_port_s = 1'b0;
        end
        win_addr_s = win_port_s ? paddr1_q : paddr0_q;
        grant_s    = (state_q == ST_IDLE) && (pend0_q || pend1_q);
        hit_s      = addr_ok_q && (win_addr_s == rom_addr_q);
    end

    // Pending slots; a request on the grant edge refills the freed slot.
    always_comb begin
        pend0_d  = pend0_q;
        paddr0_d = paddr0_q;
        pend1_d  = pend1_q;
        paddr1_d = paddr1_q;
        if (bus.req0 && (!pend0_q || (grant_s && !win_port_s))) begin
            pend0_d  = 1'b1;
            paddr0_d = bus.addr0;
        end else if (grant_s && !win_port_s) begin
            pend0_d  = 1'b0;
        end else begin
            pend0_d  = pend0_q;
        end
        if (bus.req1 && (!pend1_q || (grant_s && win_port_s))) begin
            pend1_d  = 1'b1;
            paddr1_d = bus.addr1;
        end else if (grant_s && win_port_s) begin
            pend1_d  = 1'b0;
        end else begin
            pend1_d  = pend1_q;
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = hit_s ? ST_HIT : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HIT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath updates of the sequencer.
    always_comb begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        vld0_d     = 1'b0;
        vld1_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rom_addr_d = rom_addr_q;
        addr_ok_d  = addr_ok_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    last_d  = win_port_s;
                    owner_d = win_port_s;
                    gnt0_d  = ~win_port_s;
                    gnt1_d  = win_port_s;
                    cnt_d   = 3'd0;
                    if (hit_s) begin
                        rom_addr_d = rom_addr_q;
                    end else begin
                        rom_addr_d = win_addr_s;
                        addr_ok_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rd_data_d = bus.rom_q;
                    vld0_d    = ~owner_q;
                    vld1_d    = owner_q;
                    addr_ok_d = 1'b1;
                    cnt_d     = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HIT: begin
                // Address unchanged and settled: ROM output is already valid.
                rd_data_d = bus.rom_q;
                vld0_d    = ~owner_q;
                vld1_d    = owner_q;
            end
            default: begin
                cnt_d = 3'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            paddr0_q   <= '0;
            paddr1_q   <= '0;
            rom_addr_q <= '0;
            rd_data_q  <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= 3'd0;
            addr_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            paddr0_q   <= paddr0_d;
            paddr1_q   <= paddr1_d;
            rom_addr_q <= rom_addr_d;
            rd_data_q  <= rd_data_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_ok_q  <= addr_ok_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.vld0     = vld0_q;
    assign bus.vld1     = vld1_q;
    assign bus.busy     = (state_q != ST_IDLE) || pend0_q || pend1_q;

endmodule
